// File: rtl/window_timer_arbiter_pkg.sv
// ============================================================================
// Module  : window_timer_pkg
// Brief   : Shared types and default timing constants for window_timer_arbiter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package window_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_GUARD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REL_NONE    = 2'd0,
        REL_NORMAL  = 2'd1,
        REL_TIMEOUT = 2'd2,
        REL_ABORT   = 2'd3
    } rel_cause_e;

    localparam int DEF_T_MIN = 20;
    localparam int DEF_T_MAX = 40;
    localparam int DEF_GUARD = 2;

endpackage

`default_nettype wire

// File: rtl/window_timer_arbiter_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin selector starting the search after last_i
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [$clog2(N)-1:0] sel_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        sel_o   = '0;
        valid_o = 1'b0;
        for (int i = N; i >= 1; i--) begin
            int idx;
            idx = int'(last_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                sel_o   = IW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_timer_arbiter.sv
// ============================================================================
// Module  : window_timer_arbiter
// Brief   : Round-robin owner of a shared min/max window timer with guard gap
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module window_timer_arbiter
    import window_timer_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int T_MIN = DEF_T_MIN,
    parameter int T_MAX = DEF_T_MAX,
    parameter int CNT_W = 32,
    parameter int GUARD = DEF_GUARD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_enable_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         done_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     window_active_o,
    output logic [$clog2(N_REQ)-1:0] owner_id_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     timeout_pulse_o,
    output logic                     early_done_pulse_o,
    output logic                     abort_pulse_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [CNT_W-1:0] C_T_MIN      = CNT_W'(T_MIN);
    localparam logic [CNT_W-1:0] C_T_MAX      = CNT_W'(T_MAX);
    localparam logic [GW-1:0]    C_GUARD_LAST = GW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [IW-1:0]    C_LAST_RST   = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] C_ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic             timeout_q, timeout_d;
    logic             early_q, early_d;
    logic             abort_q, abort_d;

    rel_cause_e       w_cause;
    logic             w_early;
    logic [IW-1:0]    w_sel;
    logic             w_sel_valid;
    logic             w_owner_req;
    logic             w_owner_done;
    logic             w_start;

    rr_picker #(
        .N (N_REQ)
    ) u_rr_picker (
        .req_i   (req_i),
        .last_i  (last_q),
        .sel_o   (w_sel),
        .valid_o (w_sel_valid)
    );

    assign w_owner_req  = req_i[owner_q];
    assign w_owner_done = done_i[owner_q];
    assign w_start      = cfg_enable_i && w_sel_valid;

    // Release decision on the current count; earlier branches take priority.
    always_comb begin
        w_cause = REL_NONE;
        w_early = 1'b0;
        if (state_q == ST_WINDOW) begin
            if (!w_owner_req) begin
                w_cause = REL_ABORT;
            end else if (w_owner_done && (count_q >= C_T_MIN)) begin
                w_cause = REL_NORMAL;
            end else if (count_q >= C_T_MAX) begin
                w_cause = REL_TIMEOUT;
            end else if (w_owner_done) begin
                w_early = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= C_LAST_RST;
            count_q   <= '0;
            guard_q   <= '0;
            timeout_q <= 1'b0;
            early_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            count_q   <= count_d;
            guard_q   <= guard_d;
            timeout_q <= timeout_d;
            early_q   <= early_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_WINDOW;
                end
            end
            ST_WINDOW: begin
                if (w_cause != REL_NONE) begin
                    state_d = (GUARD > 0) ? ST_GUARD : ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (guard_q == C_GUARD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        count_d   = count_q;
        guard_d   = guard_q;
        timeout_d = (w_cause == REL_TIMEOUT);
        early_d   = w_early;
        abort_d   = (w_cause == REL_ABORT);
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    grant_d = C_ONE_HOT0 << w_sel;
                    owner_d = w_sel;
                    last_d  = w_sel;
                    count_d = '0;
                end
            end
            ST_WINDOW: begin
                if (w_cause != REL_NONE) begin
                    grant_d = '0;
                    count_d = '0;
                    guard_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_GUARD: begin
                guard_d = guard_q + GW'(1);
            end
            default: begin
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    assign grant_o            = grant_q;
    assign window_active_o    = |grant_q;
    assign owner_id_o         = owner_q;
    assign count_o            = count_q;
    assign timeout_pulse_o    = timeout_q;
    assign early_done_pulse_o = early_q;
    assign abort_pulse_o      = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_window_timer_arbiter.sv
// ============================================================================
// Module  : tb_window_timer_arbiter
// Brief   : Directed self-checking bench for window_timer_arbiter (defaults)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_timer_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [3:0]  done = 4'b0000;
    logic [3:0]  grant;
    logic        window_active;
    logic [1:0]  owner_id;
    logic [31:0] count;
    logic        timeout_pulse;
    logic        early_done_pulse;
    logic        abort_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    window_timer_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_enable_i       (cfg_enable),
        .req_i              (req),
        .done_i             (done),
        .grant_o            (grant),
        .window_active_o    (window_active),
        .owner_id_o         (owner_id),
        .count_o            (count),
        .timeout_pulse_o    (timeout_pulse),
        .early_done_pulse_o (early_done_pulse),
        .abort_pulse_o      (abort_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulses = {timeout, early_done, abort}
    task automatic chk_win(input string tag, input logic [3:0] g, input int cnt,
                           input logic [2:0] pulses);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".active"}, 32'(window_active), 32'(|g));
        chk({tag, ".count"}, count, 32'(cnt));
        chk({tag, ".pulses"}, 32'({timeout_pulse, early_done_pulse, abort_pulse}), 32'(pulses));
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] exp_order [4];
    logic [3:0] cur;

    initial begin
        exp_order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        adv(2);
        chk_win("reset", 4'b0000, 0, 3'b000);
        chk("reset.owner", 32'(owner_id), 32'd0);

        // Release reset with all requesting: requester 0 first, 1-cycle latency
        req = 4'b1111; cfg_enable = 1'b1; reset = 1'b1;
        adv(1);
        chk_win("first_grant", 4'b0001, 0, 3'b000);
        chk("first_grant.owner", 32'(owner_id), 32'd0);

        // Normal done at count 25, two guard cycles, regrant on third edge
        req = 4'b0001;
        adv(25);
        chk_win("norm25.pre", 4'b0001, 25, 3'b000);
        done = 4'b0001;
        adv(1);
        chk_win("norm25.rel", 4'b0000, 0, 3'b000);
        done = 4'b0000;
        adv(1);
        chk_win("norm25.g1", 4'b0000, 0, 3'b000);
        adv(1);
        chk_win("norm25.g2", 4'b0000, 0, 3'b000);
        adv(1);
        chk_win("norm25.regrant", 4'b0001, 0, 3'b000);

        // Early done at 10, then timeout at 40 (41-cycle grant)
        adv(10);
        done = 4'b0001;
        adv(1);
        chk_win("early10", 4'b0001, 11, 3'b010);
        done = 4'b0000;
        adv(1);
        chk_win("early10.after", 4'b0001, 12, 3'b000);
        adv(28);
        chk_win("tmo.last", 4'b0001, 40, 3'b000);
        adv(1);
        chk_win("tmo.rel", 4'b0000, 0, 3'b100);
        adv(1);
        chk_win("tmo.after", 4'b0000, 0, 3'b000);
        adv(2);
        chk_win("tmo.regrant", 4'b0001, 0, 3'b000);

        // Boundary: done at 19 ignored, done at 20 accepted
        adv(19);
        done = 4'b0001;
        adv(1);
        chk_win("bnd19", 4'b0001, 20, 3'b010);
        adv(1);
        chk_win("bnd20", 4'b0000, 0, 3'b000);
        done = 4'b0000;
        adv(3);
        chk_win("bnd20.regrant", 4'b0001, 0, 3'b000);

        // Boundary: done together with count==T_MAX is a normal release
        adv(40);
        chk_win("bnd40.pre", 4'b0001, 40, 3'b000);
        done = 4'b0001;
        adv(1);
        chk_win("bnd40.rel", 4'b0000, 0, 3'b000);
        done = 4'b0000;
        adv(3);
        chk_win("bnd40.regrant", 4'b0001, 0, 3'b000);

        // Abort: owner drops req at count 5
        adv(5);
        req = 4'b0000;
        adv(1);
        chk_win("abort.rel", 4'b0000, 0, 3'b001);
        adv(1);
        chk_win("abort.after", 4'b0000, 0, 3'b000);
        req = 4'b1111;
        adv(2);
        chk_win("abort.next", 4'b0010, 0, 3'b000);
        chk("abort.next.owner", 32'(owner_id), 32'd1);

        // Asynchronous reset mid-window at count 30
        adv(30);
        chk("rst.pre.count", count, 32'd30);
        reset = 1'b0;
        #1;
        chk_win("rst.async", 4'b0000, 0, 3'b000);
        chk("rst.async.owner", 32'(owner_id), 32'd0);
        adv(1);
        reset = 1'b1;
        adv(1);
        chk_win("rst.regrant", 4'b0001, 0, 3'b000);
        chk("rst.regrant.owner", 32'(owner_id), 32'd0);

        // Round-robin rotation with done at 20; foreign done ignored
        cur = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                adv(5);
                done = 4'b0100;
                adv(1);
                chk_win("rr.foreign_done", 4'b0010, 6, 3'b000);
                done = 4'b0000;
                adv(14);
            end else begin
                adv(20);
            end
            chk_win($sformatf("rr%0d.pre", k), cur, 20, 3'b000);
            done = cur;
            adv(1);
            chk_win($sformatf("rr%0d.rel", k), 4'b0000, 0, 3'b000);
            done = 4'b0000;
            adv(3);
            chk_win($sformatf("rr%0d.next", k), exp_order[k], 0, 3'b000);
            cur = exp_order[k];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/window_timer_arbiter.md
Name: window_timer_arbiter

Overview:
Shares a single min/max window timer among N_REQ requesters.
- Grants one requester at a time, round-robin.
- Times the granted window and closes it on a qualified done, on a timeout, or on an abort.
- Inserts guard cycles between windows.
- Sits between requesting agents and the shared timed resource; the one-hot grant is the resource's enable.

Parameters:
N_REQ, 4, number of requesters (≥2)
T_MIN, 20, minimum count at which a done is accepted
T_MAX, 40, count at which the window times out (T_MAX > T_MIN)
CNT_W, 32, counter width; must satisfy 2**CNT_W > T_MAX
GUARD, 2, idle cycles after each window release (0 allowed)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
cfg_enable  input  1  allows new grants when high
req  input  N_REQ  per-requester request level
done  input  N_REQ  per-requester window-complete strobe
grant  output  N_REQ  one-hot grant, registered
window_active  output  1  high while any grant is asserted
owner_id  output  $clog2(N_REQ)  index of current/last owner
count  output  CNT_W  cycles elapsed in current window
timeout_pulse  output  1  one-cycle pulse on timeout release
early_done_pulse  output  1  one-cycle pulse on ignored early done
abort_pulse  output  1  one-cycle pulse on owner-abort release

Behaviour:
- Clock and reset: reset reset, asynchronous, active-low; clock clk.
- Reset values while reset is low:
  - state=IDLE; grant=0; window_active=0; count=0; all pulses=0.
  - owner_id=0; round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, WINDOW, GUARD.
- IDLE:
  - If cfg_enable && |req: pick the first set req index searching last+1, last+2, … (mod N_REQ).
  - Next edge: grant[sel]=1, owner_id=sel, last=sel, count=0, go to WINDOW.
  - Latency from req to grant is 1 cycle.
- WINDOW:
  - count increments by 1 each cycle.
  - Release conditions are evaluated on the current count value, in priority order:
    1. !req[owner]: abort. abort_pulse=1 next cycle.
    2. done[owner] && count >= T_MIN: normal release, no pulse.
    3. count >= T_MAX: timeout. timeout_pulse=1 next cycle.
    4. done[owner] && count < T_MIN: done is ignored, window continues. early_done_pulse=1 next cycle.
  - On release, the next edge sets grant=0 and count=0, then goes to GUARD (or to IDLE if GUARD==0).
  - done from non-owners is ignored; it raises no pulses.
  - Maximum grant length is T_MAX+1 cycles (count 0..T_MAX).
- GUARD:
  - Internal guard counter runs GUARD cycles with grant=0, then goes to IDLE.
  - req/done are ignored during GUARD.
- cfg_enable:
  - Gates only the IDLE→WINDOW transition.
  - Deasserting it mid-window does not end the window.
- Simultaneous events:
  - done and count==T_MAX in the same cycle: normal release, no timeout_pulse.
  - Abort beats everything.
- Pulse and status outputs:
  - Pulses are registered, exactly 1 cycle, mutually exclusive.
  - window_active == |grant at all times.
  - grant is never more than one-hot.
- Counter never exceeds T_MAX, so no wrap occurs.
- Reset asserted mid-window: all state returns to reset values immediately (asynchronous), including the pointer.

Decomposition:
- Package window_timer_pkg holds:
  - state enum typedef (IDLE, WINDOW, GUARD);
  - release-cause enum (NONE, NORMAL, TIMEOUT, ABORT);
  - default T_MIN/T_MAX/GUARD constants.
- One sub-module: rr_picker (combinational round-robin selector: req, last → sel index, valid). It is reusable by other arbiters.
- FSM, counter and pulses stay in the top module.

Test Plan:
- Reset release with req=4'b1111, cfg_enable=1 → grant=4'b0001 one cycle later; owner_id=0; count=0.
- req0 held, done[0] at count=25 → grant=0 next cycle; 2 guard cycles; no pulses; regrant to req0 on the 3rd cycle after release if req0 is still high.
- done[0] at count=10, no further done → early_done_pulse at count=11 cycle; timeout at count=40; timeout_pulse=1; grant high for exactly 41 cycles.
- Boundaries:
  - done at count=19 → early, ignored;
  - done at count=20 → accepted;
  - done at count=40 → normal release, timeout_pulse stays 0.
- req=4'b1111 constant, each owner asserts done at count=20 → grant order 0001,0010,0100,1000,0001; done[2] pulsed while owner=1 has no effect.
- Owner drops req at count=5 → abort_pulse, grant=0 next cycle.
- Reset pulled low at count=30 → grant=0, count=0 asynchronously; after reset release, requester 0 is served first again.
